// File: rtl/skid_buffer.sv
// skid_buffer: two-entry ready/valid slice with registered in_ready; SKID_BUF_STALL_CTR_EN adds stall_count
module skid_buffer #(
  parameter int DATA_WIDTH = 4
`ifdef SKID_BUF_STALL_CTR_EN
  , parameter int CTR_WIDTH = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst_aL,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
`ifdef SKID_BUF_STALL_CTR_EN
  , output logic [CTR_WIDTH-1:0] stall_count
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic                  in_fire, out_fire;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // next state and slot contents; empty slots are always forced to zero
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data;
        end
        BUSY: if (in_fire && out_fire) main_d = in_data;
        else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = '0;
        end
        FULL: if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
          skid_d  = '0;
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end
  // state and slot registers
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
`ifdef SKID_BUF_STALL_CTR_EN
  logic [CTR_WIDTH-1:0] stall_count_q, stall_count_d;
  assign stall_count = stall_count_q;
  // saturating count of cycles a beat waits on downstream; flush leaves it alone
  always_comb stall_count_d = (out_valid && !out_ready && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
  // stall counter register
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) stall_count_q <= '0;
    else stall_count_q <= stall_count_d;
  end
`endif
endmodule
